// File: rtl/status_reg.sv
// status_reg: processor status flags N V D I Z C with push/pull formatting, IRQ gating and branch test.
// Define STATUS_REG_BCD_EN to drive bcd from D; otherwise bcd is tied low.
module status_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_c_out,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic [2:0] set_op,
    input  logic       pull_en,
    input  logic [7:0] pull_data,
    input  logic       push_brk,
    input  logic       instr_done,
    input  logic       irq_in,
    input  logic [2:0] cond,
    output logic [7:0] p_out,
    output logic       c_in,
    output logic       bcd,
    output logic       irq_mask,
    output logic       irq_req,
    output logic       branch_taken
);
    localparam logic [2:0] CLC = 3'd1, SEC = 3'd2, CLD = 3'd3, SED = 3'd4, CLI = 3'd5, SEI = 3'd6, CLV = 3'd7;
    logic n, v, d, i, z, c, i_eff;
    logic n_nx, v_nx, d_nx, i_nx, z_nx, c_nx, sel_flag;
    always_comb begin
        n_nx = pull_en ? pull_data[7] : upd_nz ? alu_negative : n;
        z_nx = pull_en ? pull_data[1] : upd_nz ? alu_zero : z;
        c_nx = pull_en ? pull_data[0] : set_op == CLC ? 1'b0 : set_op == SEC ? 1'b1 : upd_c ? alu_c_out : c;
        v_nx = pull_en ? pull_data[6] : set_op == CLV ? 1'b0 : upd_v ? alu_overflow : v;
        d_nx = pull_en ? pull_data[3] : set_op == CLD ? 1'b0 : set_op == SED ? 1'b1 : d;
        i_nx = pull_en ? pull_data[2] : set_op == CLI ? 1'b0 : set_op == SEI ? 1'b1 : i;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            {n, v, d, z, c} <= 5'b0;
            i <= 1'b1;
            i_eff <= 1'b1;
        end else begin
            {n, v, d, i, z, c} <= {n_nx, v_nx, d_nx, i_nx, z_nx, c_nx};
            // i_eff samples the pre-write I so mask changes take effect one instruction late
            i_eff <= instr_done ? i : i_eff;
        end
    end
    assign p_out = {n, v, 1'b1, push_brk, d, i, z, c};
    assign c_in = c;
    assign irq_mask = i;
    assign irq_req = irq_in & ~i_eff;
    assign sel_flag = cond[2] ? (cond[1] ? z : c) : (cond[1] ? v : n);
    assign branch_taken = sel_flag == cond[0];
`ifdef STATUS_REG_BCD_EN
    assign bcd = d;
`else
    assign bcd = 1'b0;
`endif
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: directed and randomized checks of status_reg against a bit-mask model of P.
module tb_status_reg;
    logic clk = 0, reset = 0;
    logic alu_zero = 0, alu_negative = 0, alu_overflow = 0, alu_c_out = 0;
    logic upd_nz = 0, upd_c = 0, upd_v = 0, pull_en = 0, push_brk = 0, instr_done = 0, irq_in = 0;
    logic [2:0] set_op = 0, cond = 0;
    logic [7:0] pull_data = 0;
    logic [7:0] p_out;
    logic c_in, bcd, irq_mask, irq_req, branch_taken;
    int total = 0, bad = 0;
`ifdef STATUS_REG_BCD_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif
    // model: P byte with bits 5,4 kept zero, plus effective interrupt mask
    logic [7:0] mp = 8'h04;
    logic meff = 1'b1;
    int flag_bit [4] = '{7, 6, 0, 1};
    int op_bit [8] = '{0, 0, 0, 3, 3, 2, 2, 6};
    logic op_val [8] = '{0, 0, 1, 0, 1, 0, 1, 0};

    status_reg dut (
        .clk(clk), .reset(reset), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_c_out(alu_c_out), .upd_nz(upd_nz), .upd_c(upd_c),
        .upd_v(upd_v), .set_op(set_op), .pull_en(pull_en), .pull_data(pull_data),
        .push_brk(push_brk), .instr_done(instr_done), .irq_in(irq_in), .cond(cond),
        .p_out(p_out), .c_in(c_in), .bcd(bcd), .irq_mask(irq_mask), .irq_req(irq_req),
        .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [7:0] np;
        logic ne;
        np = mp;
        ne = instr_done ? mp[2] : meff;
        if (upd_nz) begin np[7] = alu_negative; np[1] = alu_zero; end
        if (upd_c) np[0] = alu_c_out;
        if (upd_v) np[6] = alu_overflow;
        if (set_op != 0) np[op_bit[set_op]] = op_val[set_op];
        if (pull_en) np = pull_data & 8'hCF;
        if (reset) begin np = 8'h04; ne = 1'b1; end
        @(posedge clk);
        mp = np;
        meff = ne;
        #1;
    endtask

    task automatic idle();
        {upd_nz, upd_c, upd_v, pull_en, instr_done, reset} = '0;
        set_op = 0;
    endtask

    task automatic test_reset();
        idle();
        irq_in = 1;
        reset = 1;
        tick();
        reset = 0;
        tick();
        total += 5;
        if (p_out !== 8'h24) begin bad++; $display("FAIL reset_p_out got=%h want=24", p_out); end
        if (irq_mask !== 1'b1) begin bad++; $display("FAIL reset_irq_mask got=%b want=1", irq_mask); end
        if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_irq_req got=%b want=0", irq_req); end
        if (c_in !== 1'b0) begin bad++; $display("FAIL reset_c_in got=%b want=0", c_in); end
        if (bcd !== 1'b0) begin bad++; $display("FAIL reset_bcd got=%b want=0", bcd); end
    endtask

    task automatic test_alu_update();
        idle();
        {upd_nz, upd_c, alu_negative, alu_zero, alu_c_out} = 5'b11101;
        tick();
        idle();
        cond = 3'b101;
        #1;
        total += 2;
        if (p_out !== 8'hA5) begin bad++; $display("FAIL alu_p_out got=%h want=a5", p_out); end
        if (branch_taken !== 1'b1) begin bad++; $display("FAIL alu_branch got=%b want=1", branch_taken); end
    endtask

    task automatic test_set_vs_alu();
        idle();
        set_op = 2; upd_c = 1; alu_c_out = 0;
        tick();
        total++;
        if (c_in !== 1'b1) begin bad++; $display("FAIL sec_over_alu got=%b want=1", c_in); end
        idle();
        upd_v = 1; alu_overflow = 1;
        tick();
        set_op = 7;
        tick();
        total += 2;
        if (p_out[6] !== 1'b0) begin bad++; $display("FAIL clv_over_alu got=%b want=0", p_out[6]); end
        if (c_in !== 1'b1) begin bad++; $display("FAIL clv_keeps_c got=%b want=1", c_in); end
    endtask

    task automatic test_pull();
        idle();
        pull_en = 1; pull_data = 8'hFF; set_op = 1; push_brk = 0;
        tick();
        idle();
        total += 2;
        if (p_out !== 8'hEF) begin bad++; $display("FAIL pull_p_out got=%h want=ef", p_out); end
        if (c_in !== 1'b1) begin bad++; $display("FAIL pull_over_clc got=%b want=1", c_in); end
    endtask

    task automatic test_irq_latency();
        idle();
        irq_in = 1;
        set_op = 5;
        tick();
        idle();
        total += 2;
        if (irq_mask !== 1'b0) begin bad++; $display("FAIL cli_mask got=%b want=0", irq_mask); end
        if (irq_req !== 1'b0) begin bad++; $display("FAIL cli_no_req got=%b want=0", irq_req); end
        tick();
        total++;
        if (irq_req !== 1'b0) begin bad++; $display("FAIL cli_wait got=%b want=0", irq_req); end
        instr_done = 1;
        tick();
        idle();
        total++;
        if (irq_req !== 1'b1) begin bad++; $display("FAIL cli_req got=%b want=1", irq_req); end
        set_op = 6; instr_done = 1;
        tick();
        idle();
        total += 2;
        if (irq_req !== 1'b1) begin bad++; $display("FAIL sei_late got=%b want=1", irq_req); end
        if (irq_mask !== 1'b1) begin bad++; $display("FAIL sei_mask got=%b want=1", irq_mask); end
        instr_done = 1;
        tick();
        idle();
        total++;
        if (irq_req !== 1'b0) begin bad++; $display("FAIL sei_masked got=%b want=0", irq_req); end
    endtask

    task automatic test_bcd();
        idle();
        set_op = 4;
        tick();
        idle();
        total += 2;
        if (bcd !== BCD_EN) begin bad++; $display("FAIL sed_bcd got=%b want=%b", bcd, BCD_EN); end
        if (p_out[3] !== 1'b1) begin bad++; $display("FAIL sed_p_bit3 got=%b want=1", p_out[3]); end
    endtask

    task automatic test_reset_mid();
        idle();
        reset = 1; pull_en = 1; pull_data = 8'hC3; set_op = 2; upd_nz = 1; alu_negative = 1;
        tick();
        idle();
        push_brk = 0;
        total++;
        if (p_out !== 8'h24) begin bad++; $display("FAIL reset_mid got=%h want=24", p_out); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            logic [7:0] ep;
            logic eb;
            reset = ($urandom_range(0, 39) == 0);
            {alu_zero, alu_negative, alu_overflow, alu_c_out} = 4'($urandom);
            {upd_nz, upd_c, upd_v, push_brk, instr_done, irq_in} = 6'($urandom);
            pull_en = ($urandom_range(0, 7) == 0);
            pull_data = 8'($urandom);
            set_op = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'd0;
            tick();
            cond = 3'($urandom);
            #1;
            ep = mp | 8'h20 | (push_brk ? 8'h10 : 8'h00);
            eb = mp[flag_bit[cond[2:1]]] == cond[0];
            total += 6;
            if (p_out !== ep) begin bad++; $display("FAIL rnd_p_out k=%0d got=%h want=%h", k, p_out, ep); end
            if (c_in !== mp[0]) begin bad++; $display("FAIL rnd_c_in k=%0d got=%b want=%b", k, c_in, mp[0]); end
            if (irq_mask !== mp[2]) begin bad++; $display("FAIL rnd_irq_mask k=%0d got=%b want=%b", k, irq_mask, mp[2]); end
            if (irq_req !== (irq_in & ~meff)) begin bad++; $display("FAIL rnd_irq_req k=%0d got=%b want=%b", k, irq_req, irq_in & ~meff); end
            if (bcd !== (BCD_EN & mp[3])) begin bad++; $display("FAIL rnd_bcd k=%0d got=%b want=%b", k, bcd, BCD_EN & mp[3]); end
            if (branch_taken !== eb) begin bad++; $display("FAIL rnd_branch k=%0d cond=%0d got=%b want=%b", k, cond, branch_taken, eb); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_update();
        test_set_vs_alu();
        test_pull();
        test_irq_latency();
        test_bcd();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/status_reg.md
STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: alu_zero, alu_negative, alu_overflow, alu_c_out  in  1 each  ALU flag results.
REQ-004 SHALL have port: upd_nz  in  1  load N,Z from ALU this cycle.
REQ-005 SHALL have ports: upd_c, upd_v  in  1 each  load C, V from ALU this cycle.
REQ-006 SHALL have port: set_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLD, 4 SED, 5 CLI, 6 SEI, 7 CLV.
REQ-007 SHALL have ports: pull_en  in  1  and pull_data  in  8  load P from stack byte (PLP/RTI).
REQ-008 SHALL have ports: push_brk  in  1  B bit for push byte; instr_done  in  1  instruction boundary strobe.
REQ-009 SHALL have ports: irq_in  in  1  level IRQ request; cond  in  3  branch select {N,V,C,Z}x{clear,set}.
REQ-010 SHALL have ports: p_out  out  8  push byte; c_in  out  1  to ALU; bcd  out  1  to ALU; irq_mask  out  1  current I.
REQ-011 SHALL have ports: irq_req  out  1  IRQ accepted; branch_taken  out  1  condition result.

Function
REQ-012 SHALL store registered flags N, V, D, I, Z, C; no other architectural state except i_eff (REQ-019).
REQ-013 SHALL format p_out combinationally as {N, V, 1, push_brk, D, I, Z, C}.
REQ-014 SHALL drive c_in = C and irq_mask = I combinationally from registered state.
REQ-015 SHALL apply one write source per flag per cycle, priority pull_en > set_op > ALU update.
REQ-016 pull_en SHALL load N,V,D,I,Z,C from pull_data bits 7,6,3,2,1,0; bits 5,4 ignored.
REQ-017 set_op SHALL modify only its target flag; all other flags still accept ALU updates in the same cycle.
REQ-018 upd_nz SHALL load N=alu_negative, Z=alu_zero; upd_c loads C=alu_c_out; upd_v loads V=alu_overflow; flags with no write hold.
REQ-019 SHALL keep i_eff, loaded from I only on cycles where instruction-done is asserted, giving one-instruction latency for CLI/SEI/PLP.
REQ-020 SHALL drive irq_req = irq_in & ~i_eff, combinational, no latching of irq_in.
REQ-021 SHALL decode cond[2:1] as 0 N, 1 V, 2 C, 3 Z and take branch when flag equals cond[0]; combinational.
REQ-022 When instr_done and a write to I coincide, i_eff SHALL take the pre-write I value.

Reset
REQ-023 reset SHALL set N=V=D=Z=C=0, I=1, i_eff=1 on the next rising edge, overriding all inputs.
REQ-024 After reset: p_out=8'h24 (push_brk=0), c_in=0, bcd=0, irq_mask=1, irq_req=0.
REQ-025 reset asserted mid-instruction SHALL discard any pending pull/set/update in that cycle.

Configuration
REQ-026 Macro STATUS_REG_BCD_EN defined: bcd = D.
REQ-027 Macro STATUS_REG_BCD_EN undefined: bcd tied 0; D still stored, set/cleared, pulled and pushed normally.

Verification
REQ-028 reset, then idle -> p_out=8'h24, irq_mask=1, irq_req=0 with irq_in=1.
REQ-029 upd_nz=upd_c=1, alu_negative=1, alu_zero=0, alu_c_out=1 -> next cycle p_out=8'hA5; cond=3'b101 -> branch_taken=1.
REQ-030 set_op=SEC with upd_c=1, alu_c_out=0 same cycle -> C=1; set_op=CLV with upd_v=1, alu_overflow=1 -> V=0.
REQ-031 pull_en=1, pull_data=8'hFF with set_op=CLC -> p_out=8'hEF (push_brk=0); C=1, B/bit5 unaffected by pull.
REQ-032 irq_in=1, set_op=CLI -> irq_req stays 0 until the cycle after the next instr_done, then 1; SEI+instr_done same cycle keeps irq_req=1 one more instruction.
REQ-033 set_op=SED -> bcd=1 with STATUS_REG_BCD_EN, bcd=0 without; p_out bit3=1 in both builds.
